// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: register map, STATUS bit positions, FSM states.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  localparam logic [2:0] ADDR_PR     = 3'b000;
  localparam logic [2:0] ADDR_DATA   = 3'b001;
  localparam logic [2:0] ADDR_STATUS = 3'b011;

  localparam int unsigned STAT_EMPTY  = 0;
  localparam int unsigned STAT_FULL   = 1;
  localparam int unsigned STAT_OVR    = 2;
  localparam int unsigned STAT_FERR   = 3;
  localparam int unsigned STAT_RXDONE = 4;
  localparam int unsigned STAT_BUSY   = 5;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHi
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO, 2^FIFO_AW entries, all usable; a separate count tells full from empty.
module uart_rx_fifo #(
  parameter int unsigned FIFO_AW = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [uart_pkg::DATA_W-1:0] din,
  output logic [uart_pkg::DATA_W-1:0] dout,
  output logic                      full,
  output logic                      empty
);
  import uart_pkg::*;

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DepthCnt = Depth[FIFO_AW:0];

  logic [DATA_W-1:0]  mem_q [Depth];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q;
  logic               do_push, do_pop;

  assign full    = (count_q == DepthCnt);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with register port and receive FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling of each bit (needs PR >= 1).
module uart_rx #(
  parameter logic [7:0]  PERIOD  = 8'h1A,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wren,
  input  logic       rden,
  input  logic [2:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       rxin
);
  import uart_pkg::*;

  rx_state_e  state_q;
  logic       rx_m, rx_s;
  logic [7:0] pr_q, pr_eff_q, sreg_q;
  logic [8:0] timer_q, limit;
  logic [2:0] bitcnt_q;
  logic       running, tick, sample_ev, sample_bit;
  logic       rxdone_q, ferr_q, ovr_q;
  logic       frame_ok, frame_bad;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_dout, status;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rxin;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic rx_h1, rx_h2, tick_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_h1  <= 1'b1;
      rx_h2  <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      rx_h1  <= rx_s;
      rx_h2  <= rx_h1;
      tick_q <= tick;
    end
  end

  // Act one clock after the nominal sample so the sample+1 value can join the vote.
  assign sample_ev  = tick_q;
  assign sample_bit = (rx_s & rx_h1) | (rx_s & rx_h2) | (rx_h1 & rx_h2);
`else
  assign sample_ev  = tick;
  assign sample_bit = rx_s;
`endif

  always_comb begin
    running = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
    // Half a bit (H-1 = PR) to centre on the start bit, then full bits (T-1 = 2PR+1).
    limit   = (state_q == StStart) ? {1'b0, pr_eff_q} : {pr_eff_q, 1'b1};
    tick    = running && (timer_q == limit);

    frame_ok  = sample_ev && (state_q == StStop) && sample_bit;
    frame_bad = sample_ev && (state_q == StStop) && !sample_bit;
    fifo_push = frame_ok && !fifo_full;
    fifo_pop  = rden && (addr == ADDR_DATA) && !fifo_empty;

    status              = 8'h00;
    status[STAT_BUSY]   = (state_q != StIdle);
    status[STAT_RXDONE] = rxdone_q;
    status[STAT_FERR]   = ferr_q;
    status[STAT_OVR]    = ovr_q;
    status[STAT_FULL]   = fifo_full;
    status[STAT_EMPTY]  = fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      timer_q  <= '0;
      pr_eff_q <= PERIOD;
      bitcnt_q <= '0;
      sreg_q   <= '0;
    end else begin
      if (tick) begin
        timer_q  <= '0;
        pr_eff_q <= pr_q;
      end else if (running) begin
        timer_q <= timer_q + 9'd1;
      end

      case (state_q)
        StIdle: begin
          if (!rx_s) begin
            state_q  <= StStart;
            timer_q  <= '0;
            pr_eff_q <= pr_q;
          end
        end
        StStart: begin
          if (sample_ev) begin
            if (!sample_bit) begin
              bitcnt_q <= '0;
              state_q  <= StData;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StData: begin
          if (sample_ev) begin
            sreg_q   <= {sample_bit, sreg_q[7:1]};
            bitcnt_q <= bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              state_q <= StStop;
            end
          end
        end
        StStop: begin
          if (sample_ev) begin
            state_q <= sample_bit ? StIdle : StWaitHi;
          end
        end
        StWaitHi: begin
          if (rx_s) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pr_q     <= PERIOD;
      rxdone_q <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      dout     <= 8'h00;
    end else begin
      if (wren && (addr == ADDR_PR)) begin
        pr_q <= din;
      end
      if (wren && (addr == ADDR_STATUS)) begin
        rxdone_q <= rxdone_q & din[STAT_RXDONE];
        ferr_q   <= ferr_q & din[STAT_FERR];
        ovr_q    <= ovr_q & din[STAT_OVR];
      end
      // Later assignments win, so a set in the same cycle overrides a clear.
      if (frame_ok) begin
        rxdone_q <= 1'b1;
      end
      if (frame_ok && fifo_full) begin
        ovr_q <= 1'b1;
      end
      if (frame_bad) begin
        ferr_q <= 1'b1;
      end

      if (rden) begin
        case (addr)
          ADDR_PR:     dout <= pr_q;
          ADDR_DATA:   dout <= fifo_empty ? 8'h00 : fifo_dout;
          ADDR_STATUS: dout <= status;
          default:     dout <= 8'h00;
        endcase
      end
    end
  end

  uart_rx_fifo #(
    .FIFO_AW(FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (sreg_q),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed steps plus random frames against a queue-based model.
module tb_uart_rx;

  localparam logic [2:0] A_PR   = 3'b000;
  localparam logic [2:0] A_DATA = 3'b001;
  localparam logic [2:0] A_STAT = 3'b011;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       wren  = 1'b0;
  logic       rden  = 1'b0;
  logic [2:0] addr  = 3'b000;
  logic [7:0] din   = 8'h00;
  logic [7:0] dout;
  logic       rxin  = 1'b1;

  uart_rx #(
    .PERIOD  (8'h1A),
    .FIFO_AW (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .wren  (wren),
    .rden  (rden),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .rxin  (rxin)
  );

  always #5 clk = ~clk;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model: received bytes as a bounded queue plus the three sticky flags.
  logic [7:0]  exp_q[$];
  bit          m_rxdone, m_ferr, m_ovr;
  int unsigned bt;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_status(input bit busy);
    exp_status = {2'b00, busy, m_rxdone, m_ferr, m_ovr,
                  (exp_q.size() == 8), (exp_q.size() == 0)};
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_rxdone = 1'b0;
    m_ferr   = 1'b0;
    m_ovr    = 1'b0;
    bt       = 2 * (8'h1A + 1);
  endfunction

  // All tasks start and end on a falling edge.
  task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
    wren = 1'b1;
    addr = a;
    din  = d;
    @(negedge clk);
    wren = 1'b0;
  endtask

  task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
    rden = 1'b1;
    addr = a;
    @(negedge clk);
    rden = 1'b0;
    d    = dout;
  endtask

  task automatic set_period(input logic [7:0] p);
    logic [7:0] d;
    reg_write(A_PR, p);
    bt = 2 * (int'(p) + 1);
    reg_read(A_PR, d);
    check("pr_readback", d, p);
  endtask

  task automatic clear_status(input logic [7:0] d);
    reg_write(A_STAT, d);
    m_rxdone = m_rxdone & d[4];
    m_ferr   = m_ferr & d[3];
    m_ovr    = m_ovr & d[2];
  endtask

  task automatic send_bits(input logic [7:0] b);
    rxin = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxin = b[i];
      repeat (bt) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int unsigned stop_len);
    send_bits(b);
    rxin = stop_ok;
    repeat (stop_len) @(negedge clk);
    rxin = 1'b1;
    repeat (bt + 4) @(negedge clk);
    if (stop_ok) begin
      m_rxdone = 1'b1;
      if (exp_q.size() < 8) exp_q.push_back(b);
      else m_ovr = 1'b1;
    end else begin
      m_ferr = 1'b1;
    end
  endtask

  task automatic read_data(input string tag);
    logic [7:0] d, e;
    reg_read(A_DATA, d);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check(tag, d, e);
  endtask

  task automatic read_status(input string tag);
    logic [7:0] d;
    reg_read(A_STAT, d);
    check(tag, d, exp_status(1'b0));
  endtask

  initial begin
    logic [7:0] d;
    int unsigned op;

    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("reset_dout", dout, 8'h00);
    reg_read(A_PR, d);
    check("reset_pr", d, 8'h1A);
    reg_read(A_STAT, d);
    check("reset_status", d, 8'h01);

    // Basic frame at T=4
    set_period(8'h01);
    send_frame(8'h55, 1'b1, bt);
    reg_read(A_STAT, d);
    check("basic_status", d, 8'h10);
    read_data("basic_data");
    read_status("basic_empty_again");
    read_data("empty_read");

    // Framing error with a long low stop bit, then a clean frame
    send_bits(8'hA3);
    rxin = 1'b0;
    repeat (10) @(negedge clk);
    m_ferr = 1'b1;
    reg_read(A_STAT, d);
    check("ferr_held_low", d, exp_status(1'b1));
    repeat (8) @(negedge clk);
    rxin = 1'b1;
    repeat (bt + 4) @(negedge clk);
    read_status("ferr_line_high");
    send_frame(8'h3C, 1'b1, bt);
    read_data("after_ferr_data");

    // Overrun: nine frames with no reads
    clear_status(8'h00);
    read_status("cleared");
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, bt);
    reg_read(A_STAT, d);
    check("overrun_status", d, 8'h16);
    send_frame(8'hEE, 1'b0, bt + 3);
    read_status("ovr_and_ferr");
    clear_status(8'h08);
    reg_read(A_STAT, d);
    check("sticky_clear", d, 8'h0A);
    for (int i = 0; i < 8; i++) read_data("overrun_drain");
    read_status("drained");

    // Glitch rejection
    set_period(8'h03);
    rxin = 1'b0;
    repeat (2) @(negedge clk);
    rxin = 1'b1;
    repeat (20) @(negedge clk);
    read_status("glitch_rejected");

`ifdef UART_RX_MAJORITY_EN
    // One-clock low pulse exactly at the bit-3 sample point
    rxin = 1'b0;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxin = 1'b1;
      if (i == 3) begin
        repeat (bt / 2) @(negedge clk);
        rxin = 1'b0;
        @(negedge clk);
        rxin = 1'b1;
        repeat (bt - bt / 2 - 1) @(negedge clk);
      end else begin
        repeat (bt) @(negedge clk);
      end
    end
    repeat (bt + 4) @(negedge clk);
    m_rxdone = 1'b1;
    exp_q.push_back(8'hFF);
    read_data("majority_glitch");
`endif

    // Reset in the middle of a frame with data already queued
    set_period(8'h01);
    send_frame(8'h9A, 1'b1, bt);
    reg_read(A_STAT, d);
    rxin = 1'b0;
    repeat (bt * 3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    rxin  = 1'b1;
    reset = 1'b1;
    model_reset();
    check("midreset_dout", dout, 8'h00);
    reg_read(A_PR, d);
    check("midreset_pr", d, 8'h1A);
    read_status("midreset_status");

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      if (i % 10 == 0) set_period(8'($urandom_range(1, 4)));
      op = $urandom_range(0, 9);
      if (op <= 4) send_frame(8'($urandom), 1'b1, bt);
      else if (op == 5) send_frame(8'($urandom), 1'b0, bt + $urandom_range(0, bt));
      else if (op <= 7) read_data("rand_data");
      else if (op == 8) read_status("rand_status");
      else begin
        clear_status(8'($urandom));
        read_status("rand_clear");
      end
    end
    while (exp_q.size() > 0) read_data("final_drain");
    read_status("final_status");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
